// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Write-side front end for the instruction cache. Bytes arrive over a
// valid/ready handshake from the boot/debug source (UART or test host). They
// are packed little-endian into instruction words, and each word is written
// to the cache with a one-cycle strobe at byte address n*bytes_per_word.
//
// Optional feature macro: ILOAD_CHECKSUM_EN
//   When defined, the loader keeps a running 8-bit sum of the data bytes and
//   takes one extra trailer byte after the last word. The load completes
//   (done_o) only if (sum + trailer) mod 256 == 0; otherwise error_o is set.
//   When undefined, there is no trailer byte and FLUSH goes straight to DONE.
//
// Ports
//   clk_i          in   1          system clock, rising edge
//   rst_n_i        in   1          asynchronous reset, active-low
//   start_i        in   1          start a load (sampled only in IDLE)
//   abort_i        in   1          cancel a load in progress
//   word_count_i   in   addr_wid   number of words to load (latched on start)
//   byte_valid_i   in   1          byte_i carries a valid byte
//   byte_i         in   8          stream byte
//   byte_ready_o   out  1          loader accepts a byte this cycle
//   wr_instr_en_o  out  1          one-cycle cache write strobe
//   wr_instr_o     out  instr_wid  assembled instruction word
//   wr_addr_o      out  addr_wid   byte address of the write
//   busy_o         out  1          high in every state except IDLE
//   done_o         out  1          one-cycle pulse on successful completion
//   error_o        out  1          sticky error, cleared by next accepted start
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int addr_wid       = 32,
  parameter int instr_wid      = 32,
  parameter int length         = 100,
  parameter int bytes_per_word = instr_wid >> 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [addr_wid-1:0]  word_count_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 byte_ready_o,
  output logic                 wr_instr_en_o,
  output logic [instr_wid-1:0] wr_instr_o,
  output logic [addr_wid-1:0]  wr_addr_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  // Byte index needs at least one bit even for single-byte words.
  localparam int BIDX_W = (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;

  localparam logic [BIDX_W-1:0]   LAST_BIDX = BIDX_W'(bytes_per_word - 1);
  localparam logic [BIDX_W-1:0]   BIDX_ONE  = BIDX_W'(1);
  localparam logic [addr_wid-1:0] LEN_A     = addr_wid'(length);
  localparam logic [addr_wid-1:0] CNT_ONE   = addr_wid'(1);
  localparam logic [addr_wid-1:0] BPW_A     = addr_wid'(bytes_per_word);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef ILOAD_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd4;
`endif

  // Place byte b into byte lane idx of word w (lane 0 = bits [7:0]).
  function automatic logic [instr_wid-1:0] insert_byte(
    input logic [instr_wid-1:0] w,
    input logic [BIDX_W-1:0]    idx,
    input logic [7:0]           b
  );
    logic [instr_wid-1:0] r;
    r = w;
    for (int k = 0; k < bytes_per_word; k++) begin
      if (idx == BIDX_W'(k)) r[8*k +: 8] = b;
    end
    return r;
  endfunction

  function automatic logic count_ok(input logic [addr_wid-1:0] cnt);
    return (cnt != '0) && (cnt <= LEN_A);
  endfunction

`ifdef ILOAD_CHECKSUM_EN
  // A load is intact when the data bytes plus the trailer sum to zero mod 256.
  function automatic logic checksum_ok(input logic [7:0] sum, input logic [7:0] trailer);
    logic [7:0] total;
    total = sum + trailer;
    return (total == 8'h00);
  endfunction
`endif

  logic [2:0]           state_q,   state_d;
  logic [addr_wid-1:0]  count_q,   count_d;    // words still to complete
  logic [BIDX_W-1:0]    bidx_q,    bidx_d;     // next byte lane to fill
  logic [instr_wid-1:0] asm_q,     asm_d;      // word under assembly
  logic [addr_wid-1:0]  addr_q,    addr_d;     // address of word under assembly
  logic                 wr_en_q,   wr_en_d;
  logic [instr_wid-1:0] wr_data_q, wr_data_d;
  logic [addr_wid-1:0]  wr_addr_q, wr_addr_d;
  logic                 error_q,   error_d;
`ifdef ILOAD_CHECKSUM_EN
  logic [7:0]           sum_q,     sum_d;
`endif
  logic                 byte_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    bidx_d     = bidx_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    error_d    = error_q;
`ifdef ILOAD_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    byte_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (count_ok(word_count_i)) begin
            error_d = 1'b0;
            count_d = word_count_i;
            addr_d  = '0;
            bidx_d  = '0;
            asm_d   = '0;
`ifdef ILOAD_CHECKSUM_EN
            sum_d   = 8'h00;
`endif
            state_d = S_LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        // Ready is withheld during abort so the handshake never reports a
        // byte as taken when it is being discarded.
        byte_ready = ~abort_i;
        if (abort_i) begin
          bidx_d  = '0;
          asm_d   = '0;
          state_d = S_IDLE;
        end else if (byte_valid_i) begin
          asm_d = insert_byte(asm_q, bidx_q, byte_i);
`ifdef ILOAD_CHECKSUM_EN
          sum_d = sum_q + byte_i;
`endif
          if (bidx_q == LAST_BIDX) begin
            // Word complete: the strobe is registered and appears next cycle
            // while the following word may already be streaming in.
            bidx_d    = '0;
            wr_en_d   = 1'b1;
            wr_data_d = asm_d;
            wr_addr_d = addr_q;
            addr_d    = addr_q + BPW_A;
            if (count_q == CNT_ONE) begin
              state_d = S_FLUSH;
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end else begin
            bidx_d = bidx_q + BIDX_ONE;
          end
        end
      end

      // The final word's strobe is on the outputs during this cycle.
      S_FLUSH: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
`ifdef ILOAD_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end

`ifdef ILOAD_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = ~abort_i;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (byte_valid_i) begin
          if (checksum_ok(sum_q, byte_i)) begin
            state_d = S_DONE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      bidx_q    <= '0;
      asm_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      error_q   <= 1'b0;
`ifdef ILOAD_CHECKSUM_EN
      sum_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bidx_q    <= bidx_d;
      asm_q     <= asm_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      error_q   <= error_d;
`ifdef ILOAD_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign byte_ready_o  = byte_ready;
  assign wr_instr_en_o = wr_en_q;
  assign wr_instr_o    = wr_data_q;
  assign wr_addr_o     = wr_addr_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign error_o       = error_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam int AW  = 32;
  localparam int IW  = 32;
  localparam int LEN = 100;
  localparam int BPW = IW / 8;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [IW-1:0] data;
    logic [AW-1:0] addr;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] wcount = '0;
  logic          bvalid = 1'b0;
  logic [7:0]    bdata = 8'h00;

  logic          byte_ready_o;
  logic          wr_instr_en_o;
  logic [IW-1:0] wr_instr_o;
  logic [AW-1:0] wr_addr_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  instr_loader #(
    .addr_wid (AW),
    .instr_wid(IW),
    .length   (LEN)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .word_count_i (wcount),
    .byte_valid_i (bvalid),
    .byte_i       (bdata),
    .byte_ready_o (byte_ready_o),
    .wr_instr_en_o(wr_instr_en_o),
    .wr_instr_o   (wr_instr_o),
    .wr_addr_o    (wr_addr_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  done_seen = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_o) done_seen++;
      if (wr_instr_en_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_strobe: got data 0x%0h addr 0x%0h, expected no write",
                   wr_instr_o, wr_addr_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_data", {32'h0, wr_instr_o}, {32'h0, mon_e.data});
          check("wr_addr", {32'h0, wr_addr_o}, {32'h0, mon_e.addr});
        end
      end
    end
  end

  // Reference model: word n is bytes [n*BPW .. n*BPW+BPW-1], little-endian,
  // written to byte address n*BPW.
  task automatic push_expected(input byte_q_t bytes, input int nwords);
    for (int n = 0; n < nwords; n++) begin
      wr_t e;
      e.data = '0;
      for (int k = 0; k < BPW; k++) e.data |= IW'(bytes[n*BPW + k]) << (8*k);
      e.addr = AW'(n * BPW);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_bytes(input int nwords, output byte_q_t bytes);
    bytes = {};
    for (int i = 0; i < nwords * BPW; i++) bytes.push_back(8'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] cnt);
    start  = 1'b1;
    wcount = cnt;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy_o && guard < 100) begin
      tick();
      guard++;
    end
    check({name, "_idle_reached"}, {63'h0, busy_o}, 64'h0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int   guard;
    logic rdy;
    bit   ok;
    for (int g = 0; g < gap; g++) begin
      bvalid = 1'b0;
      tick();
    end
    bvalid = 1'b1;
    bdata  = b;
    ok     = 1'b0;
    guard  = 0;
    while (!ok && guard < 50) begin
      @(negedge clk);
      rdy = byte_ready_o;
      tick();
      ok = rdy;
      guard++;
    end
    bvalid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byte 0x%0h not accepted, expected acceptance", b);
    end
  endtask

  // gapmode: 0 = valid held high, 1 = valid toggles, 2 = random idle gaps
  task automatic feed(input byte_q_t bytes, input int gapmode);
    foreach (bytes[i]) begin
      int gap;
      gap = (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_byte(bytes[i], gap);
    end
  endtask

  task automatic run_load(input int cnt, input byte_q_t bytes, input int gapmode, input string tag);
    int d0;
`ifdef ILOAD_CHECKSUM_EN
    logic [7:0] sum;
`endif
    wait_idle({tag, "_pre"});
    push_expected(bytes, cnt);
    d0 = done_seen;
    do_start(AW'(cnt));
    check({tag, "_busy_after_start"}, {63'h0, busy_o}, 64'h1);
    check({tag, "_error_after_start"}, {63'h0, error_o}, 64'h0);
    feed(bytes, gapmode);
`ifdef ILOAD_CHECKSUM_EN
    sum = 8'h00;
    foreach (bytes[i]) sum = sum + bytes[i];
    send_byte(8'h00 - sum, 0);
`endif
    wait_idle({tag, "_post"});
    check({tag, "_done_pulses"}, 64'(done_seen - d0), 64'h1);
    check({tag, "_error_at_end"}, {63'h0, error_o}, 64'h0);
    check({tag, "_writes_outstanding"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, {63'h0, byte_ready_o}, 64'h0);
    check({tag, "_wr_en"}, {63'h0, wr_instr_en_o}, 64'h0);
    check({tag, "_wr_instr"}, {32'h0, wr_instr_o}, 64'h0);
    check({tag, "_wr_addr"}, {32'h0, wr_addr_o}, 64'h0);
    check({tag, "_busy"}, {63'h0, busy_o}, 64'h0);
    check({tag, "_done"}, {63'h0, done_o}, 64'h0);
    check({tag, "_error"}, {63'h0, error_o}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t b;
    int      d0;

    // Reset state
    #12;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1: two words, valid held high
    b = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, b, 0, "t1");

    // Test 2: illegal counts set error, then a legal start clears it
    do_start(AW'(0));
    check("t2_err_count0", {63'h0, error_o}, 64'h1);
    check("t2_busy_count0", {63'h0, busy_o}, 64'h0);
    do_start(AW'(LEN + 1));
    check("t2_err_count101", {63'h0, error_o}, 64'h1);
    check("t2_busy_count101", {63'h0, busy_o}, 64'h0);
    tick();
    check("t2_err_sticky", {63'h0, error_o}, 64'h1);
    rand_bytes(1, b);
    run_load(1, b, 0, "t2_recover");

    // Test 3: valid toggling every other cycle
    b = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, b, 1, "t3");

    // Test 4: abort after two bytes, with a byte offered in the abort cycle
    wait_idle("t4_pre");
    d0 = done_seen;
    do_start(AW'(3));
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    abort  = 1'b1;
    bvalid = 1'b1;
    bdata  = 8'hCC;
    @(negedge clk);
    check("t4_ready_during_abort", {63'h0, byte_ready_o}, 64'h0);
    tick();
    abort  = 1'b0;
    bvalid = 1'b0;
    check("t4_busy_after_abort", {63'h0, busy_o}, 64'h0);
    tick();
    tick();
    check("t4_error_after_abort", {63'h0, error_o}, 64'h0);
    check("t4_no_done", 64'(done_seen - d0), 64'h0);
    b = {8'h37, 8'h12, 8'h00, 8'h00};
    run_load(1, b, 0, "t4_restart");

    // Test 5: asynchronous reset mid-word
    wait_idle("t5_pre");
    do_start(AW'(2));
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    rand_bytes(1, b);
    run_load(1, b, 2, "t5_fresh");

    // Randomized loads
    for (int it = 0; it < 8; it++) begin
      int cnt;
      cnt = int'($urandom_range(1, 6));
      rand_bytes(cnt, b);
      run_load(cnt, b, int'($urandom_range(0, 2)), "rand");
    end

    // Boundary: maximum legal count
    rand_bytes(LEN, b);
    run_load(LEN, b, 0, "max_len");

`ifdef ILOAD_CHECKSUM_EN
    // Test 6: good trailer completes, bad trailer sets error; write happens both times
    b = {8'h01, 8'h00, 8'h00, 8'h00};
    run_load(1, b, 0, "t6_good");
    wait_idle("t6_bad_pre");
    push_expected(b, 1);
    d0 = done_seen;
    do_start(AW'(1));
    feed(b, 0);
    send_byte(8'h00, 0);
    wait_idle("t6_bad_post");
    check("t6_bad_error", {63'h0, error_o}, 64'h1);
    check("t6_bad_no_done", 64'(done_seen - d0), 64'h0);
    check("t6_bad_write_done", 64'(exp_q.size()), 64'h0);
    rand_bytes(2, b);
    run_load(2, b, 2, "t6_recover");
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
